cic3_readout_sched: RTL and testbench
=====================================

// Module: cic3_readout_sched
// PURPOSE
//  Readout scheduler for the 2x12 CIC3 filter row. On each decimated-sample strobe it snapshots
//  all filter outputs and streams the enabled channels, lowest index first, over one
//  DATA_W-bit valid/ready port. Sits between the filter row outputs and the chip readout/serializer.
//  It also counts strobes that are dropped because the previous frame is still in flight.
// PARAMETERS
//  NUM_FILTERS  24  filters in the row (channel 0 = right-most filter)
//  DATA_W       25  filter output width
//  OVR_W        8   overrun counter width
//  CHAN_W (localparam) = $clog2(NUM_FILTERS)
// PORTS
//  clk          in   1                   filter clock; the block's only clock
//  reset        in   1                   synchronous, active-high reset
//  sample_stb   in   1                   1-clk pulse: new decimated sample on filt_data
//  filt_data    in   NUM_FILTERS*DATA_W  channel k occupies bits [(k+1)*DATA_W-1 : k*DATA_W]
//  chan_mask    in   NUM_FILTERS         1 = channel read out; sampled only on an accepted strobe
//  ovr_clr      in   1                   clears ovr_cnt and ovr_flag
//  out_ready    in   1                   downstream ready
//  out_valid    out  1                   word valid
//  out_data     out  DATA_W              captured filter sample
//  out_chan     out  CHAN_W              channel index of out_data
//  out_sof      out  1                   first word of frame
//  out_eof      out  1                   last word of frame
//  busy         out  1                   frame in progress (state SEND)
//  ovr_flag     out  1                   sticky: at least one strobe dropped
//  ovr_cnt      out  OVR_W               dropped-strobe count; saturates at all-ones
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0. Snapshot bank and pending mask cleared.
//  - States: IDLE, SEND.
//  - Strobe is "accepted" when sample_stb=1, chan_mask!=0, and either:
//      state=IDLE, or
//      state=SEND and the final word transfers in the same cycle.
//  - On acceptance:
//      filt_data latched into the snapshot bank; chan_mask latched into pend.
//      Next cycle: state=SEND, out_valid=1, out_sof=1, out_chan = lowest set bit of pend.
//      Latency is strobe + 1 cycle.
//  - sample_stb with chan_mask==0: ignored. No frame, not counted as an overrun.
//  - SEND handshake:
//      out_data, out_chan, out_sof and out_eof stay stable while out_valid & !out_ready.
//      A transfer occurs on out_valid & out_ready.
//      After a transfer the channel's pend bit clears and the next lowest set bit is
//        presented the next cycle. Back-to-back rate is one word per clk.
//      out_eof=1 when the presented channel is the only bit left in pend.
//      A single-channel frame has out_sof=out_eof=1.
//  - Frame end: when the eof word transfers with no accepted strobe, the next cycle is
//    state=IDLE and out_valid=0.
//  - Overrun: sample_stb=1 in SEND, not accepted, and chan_mask!=0:
//      ovr_cnt += 1, saturating at all-ones; ovr_flag <= 1.
//      The current frame continues unaffected.
//  - ovr_clr and an overrun in the same cycle: the clear wins, then the count applies,
//    so ovr_cnt=1 and ovr_flag=1.
//  - Changes to filt_data or chan_mask during SEND have no effect on the current frame.
//  - reset mid-frame: the frame is aborted and the reset values apply next cycle.
//    No partial eof is issued.
// CONFIGURATION
//  CIC3_RDOUT_PARITY_EN defined:
//    Adds output out_par (1 bit) = even parity over {out_chan, out_data}.
//    Held stable with the data. Reset value 0.
//  CIC3_RDOUT_PARITY_EN undefined: the port is absent and there is no parity logic.
// TESTING
//  1. mask=24'hFFFFFF, ready=1, stb at cycle 10:
//     valid cycles 11..34, chan 0..23, sof@11, eof@34; data equals the strobe-time snapshot.
//  2. mask=24'h800001, ready toggling every cycle:
//     two words, chan 0 then 23; data held through stalls; sof/eof on the correct words.
//  3. mask=24'h000010, stb in IDLE:
//     one word, chan=4, sof=eof=1; busy low the cycle after the transfer.
//  4. Strobe mid-frame (ready=0 held):
//     ovr_cnt 0->1, ovr_flag=1, frame unaltered.
//     255 more strobes leave ovr_cnt=255. ovr_clr gives 0.
//  5. Strobe coincident with eof transfer:
//     new frame starts next cycle with sof=1, no idle gap, ovr_cnt unchanged.
//  6. reset asserted mid-frame at chan 7:
//     all outputs 0 next cycle. A stb with mask=0 then causes no frame and no overrun.

Source files
------------

// File: rtl/cic3_readout_sched.sv
// Readout scheduler for the CIC3 filter row: snapshots all channels on a strobe and streams enabled ones.
// Optional build macro CIC3_RDOUT_PARITY_EN adds the out_par even-parity output.
module cic3_readout_sched #(
  parameter int NUM_FILTERS = 24,
  parameter int DATA_W      = 25,
  parameter int OVR_W       = 8,
  localparam int CHAN_W     = $clog2(NUM_FILTERS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sample_stb,
  input  logic [NUM_FILTERS*DATA_W-1:0] filt_data,
  input  logic [NUM_FILTERS-1:0]        chan_mask,
  input  logic                          ovr_clr,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic [CHAN_W-1:0]             out_chan,
  output logic                          out_sof,
  output logic                          out_eof,
  output logic                          busy,
  output logic                          ovr_flag,
  output logic [OVR_W-1:0]              ovr_cnt
`ifdef CIC3_RDOUT_PARITY_EN
  ,
  output logic                          out_par
`endif
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                        state;
  logic [NUM_FILTERS*DATA_W-1:0] snap;
  logic [NUM_FILTERS-1:0]        pend;

  logic                          xfer, last_xfer, accept, overrun;
  logic [NUM_FILTERS-1:0]        pend_left, src_mask;
  logic [NUM_FILTERS*DATA_W-1:0] src_bank;
  logic [CHAN_W-1:0]             nxt_chan;
  logic [DATA_W-1:0]             nxt_data;
  logic                          nxt_eof;

  function automatic logic [CHAN_W-1:0] lowest(input logic [NUM_FILTERS-1:0] v);
    lowest = '0;
    for (int i = NUM_FILTERS - 1; i >= 0; i--)
      if (v[i]) lowest = CHAN_W'(i);
  endfunction

  // A new strobe may ride on the final word's transfer, so the next word comes
  // either from the fresh strobe inputs or from what is left of the current frame.
  always_comb begin
    xfer      = (state == SEND) && out_valid && out_ready;
    last_xfer = xfer && out_eof;
    accept    = sample_stb && (|chan_mask) && ((state == IDLE) || last_xfer);
    overrun   = sample_stb && (|chan_mask) && (state == SEND) && !last_xfer;
    pend_left = pend & ~(NUM_FILTERS'(1) << out_chan);
    src_mask  = accept ? chan_mask : pend_left;
    src_bank  = accept ? filt_data : snap;
    nxt_chan  = lowest(src_mask);
    nxt_data  = src_bank[int'(nxt_chan)*DATA_W +: DATA_W];
    nxt_eof   = (src_mask & (src_mask - NUM_FILTERS'(1))) == '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      snap      <= '0;
      pend      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      ovr_flag  <= 1'b0;
      ovr_cnt   <= '0;
`ifdef CIC3_RDOUT_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else begin
      if (accept || (xfer && !out_eof)) begin
        state     <= SEND;
        pend      <= src_mask;
        out_valid <= 1'b1;
        out_sof   <= accept;
        out_eof   <= nxt_eof;
        out_chan  <= nxt_chan;
        out_data  <= nxt_data;
`ifdef CIC3_RDOUT_PARITY_EN
        out_par   <= ^{nxt_chan, nxt_data};
`endif
        if (accept) snap <= filt_data;
      end else if (xfer) begin
        state     <= IDLE;
        pend      <= '0;
        out_valid <= 1'b0;
        out_sof   <= 1'b0;
        out_eof   <= 1'b0;
        out_chan  <= '0;
        out_data  <= '0;
`ifdef CIC3_RDOUT_PARITY_EN
        out_par   <= 1'b0;
`endif
      end

      // A clear coinciding with an overrun leaves a count of exactly one.
      if (ovr_clr) begin
        ovr_cnt  <= overrun ? OVR_W'(1) : '0;
        ovr_flag <= overrun;
      end else if (overrun) begin
        ovr_flag <= 1'b1;
        if (ovr_cnt != '1) ovr_cnt <= ovr_cnt + OVR_W'(1);
      end
    end
  end

  assign busy = (state == SEND);

endmodule

// File: tb/tb_cic3_readout_sched.sv
// Scoreboard bench for cic3_readout_sched: stimulus pushes expected words, a negedge monitor checks them.
// Parity output is checked only when CIC3_RDOUT_PARITY_EN is defined.
module tb_cic3_readout_sched;

  localparam int NF = 24;
  localparam int DW = 25;
  localparam int OW = 8;
  localparam int CW = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             sample_stb;
  logic [NF*DW-1:0] filt_data;
  logic [NF-1:0]    chan_mask;
  logic             ovr_clr;
  logic             out_ready;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic [CW-1:0]    out_chan;
  logic             out_sof;
  logic             out_eof;
  logic             busy;
  logic             ovr_flag;
  logic [OW-1:0]    ovr_cnt;
`ifdef CIC3_RDOUT_PARITY_EN
  logic             out_par;
`endif

  typedef struct {
    logic [CW-1:0] chan;
    logic [DW-1:0] data;
    logic          sof;
    logic          eof;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  cic3_readout_sched #(.NUM_FILTERS(NF), .DATA_W(DW), .OVR_W(OW)) dut (
    .clk(clk), .reset(reset), .sample_stb(sample_stb), .filt_data(filt_data),
    .chan_mask(chan_mask), .ovr_clr(ovr_clr), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
    .out_sof(out_sof), .out_eof(out_eof), .busy(busy),
    .ovr_flag(ovr_flag), .ovr_cnt(ovr_cnt)
`ifdef CIC3_RDOUT_PARITY_EN
    , .out_par(out_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int k, input int seed);
    logic [31:0] v;
    v = (seed * 32'h0000_9E37) + (k * 32'h0001_2345) + (k << 20);
    return v[DW-1:0];
  endfunction

  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  // Issue one strobe; when the bench expects acceptance, queue the frame in channel order.
  task automatic applyStimulus(input logic [NF-1:0] mask, input int seed, input bit accept);
    exp_t e;
    bit   first;
    int   last;
    for (int k = 0; k < NF; k++) filt_data[k*DW +: DW] = pat(k, seed);
    chan_mask  = mask;
    sample_stb = 1'b1;
    if (accept) begin
      first = 1'b1;
      last  = -1;
      for (int k = 0; k < NF; k++) if (mask[k]) last = k;
      for (int k = 0; k < NF; k++) begin
        if (mask[k]) begin
          e.chan = CW'(k);
          e.data = pat(k, seed);
          e.sof  = first;
          e.eof  = (k == last);
          q.push_back(e);
          first = 1'b0;
        end
      end
    end
    wait_clk();
    sample_stb = 1'b0;
    filt_data  = ~filt_data;
    chan_mask  = ~mask;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0 && !out_valid) break;
      wait_clk();
    end
    checkOutput(name, q.size(), 0);
  endtask

  // Monitor: every presented word must match the queue head; it is retired on transfer.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (q.size() == 0) begin
        checkOutput("unexpected_word", 32'(out_valid), 0);
      end else begin
        checkOutput("mon_chan", 32'(out_chan), 32'(q[0].chan));
        checkOutput("mon_data", 32'(out_data), 32'(q[0].data));
        checkOutput("mon_sof",  32'(out_sof),  32'(q[0].sof));
        checkOutput("mon_eof",  32'(out_eof),  32'(q[0].eof));
`ifdef CIC3_RDOUT_PARITY_EN
        checkOutput("mon_par",  32'(out_par),  32'(^{q[0].chan, q[0].data}));
`endif
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;
    reset = 1'b1; sample_stb = 1'b0; filt_data = '0; chan_mask = '0;
    ovr_clr = 1'b0; out_ready = 1'b1;
    repeat (3) wait_clk();
    reset = 1'b0;
    wait_clk();
    checkOutput("rst_valid", 32'(out_valid), 0);
    checkOutput("rst_busy",  32'(busy), 0);
    checkOutput("rst_data",  32'(out_data), 0);
    checkOutput("rst_ovr",   32'(ovr_cnt), 0);
    checkOutput("rst_flag",  32'(ovr_flag), 0);

    // Full-row frame at full rate
    repeat (5) wait_clk();
    applyStimulus(24'hFFFFFF, 11, 1'b1);
    checkOutput("t1_valid", 32'(out_valid), 1);
    checkOutput("t1_sof",   32'(out_sof), 1);
    checkOutput("t1_chan0", 32'(out_chan), 0);
    repeat (23) wait_clk();
    checkOutput("t1_chan23", 32'(out_chan), 23);
    checkOutput("t1_eof",    32'(out_eof), 1);
    wait_clk();
    checkOutput("t1_end_valid", 32'(out_valid), 0);
    checkOutput("t1_end_busy",  32'(busy), 0);
    drain("t1_drain");

    // Single-channel frame
    applyStimulus(24'h000010, 33, 1'b1);
    checkOutput("t3_chan", 32'(out_chan), 4);
    checkOutput("t3_sof",  32'(out_sof), 1);
    checkOutput("t3_eof",  32'(out_eof), 1);
    wait_clk();
    checkOutput("t3_busy", 32'(busy), 0);
    drain("t3_drain");

    // Two-word frame with ready toggling
    out_ready = 1'b0;
    applyStimulus(24'h800001, 22, 1'b1);
    for (int i = 0; i < 8; i++) begin
      out_ready = ~out_ready;
      wait_clk();
    end
    out_ready = 1'b1;
    drain("t2_drain");

    // Overruns during a stalled frame
    out_ready = 1'b0;
    applyStimulus(24'h000103, 44, 1'b1);
    applyStimulus(24'hF0F0F0, 45, 1'b0);
    checkOutput("t4_ovr1",  32'(ovr_cnt), 1);
    checkOutput("t4_flag1", 32'(ovr_flag), 1);
    checkOutput("t4_busy",  32'(busy), 1);
    sample_stb = 1'b1;
    repeat (255) wait_clk();
    sample_stb = 1'b0;
    checkOutput("t4_sat", 32'(ovr_cnt), 255);
    ovr_clr = 1'b1;
    wait_clk();
    ovr_clr = 1'b0;
    checkOutput("t4_clr_cnt",  32'(ovr_cnt), 0);
    checkOutput("t4_clr_flag", 32'(ovr_flag), 0);
    ovr_clr = 1'b1; sample_stb = 1'b1; chan_mask = 24'h000001;
    wait_clk();
    ovr_clr = 1'b0; sample_stb = 1'b0;
    checkOutput("t4_clrovr_cnt",  32'(ovr_cnt), 1);
    checkOutput("t4_clrovr_flag", 32'(ovr_flag), 1);
    ovr_clr = 1'b1;
    wait_clk();
    ovr_clr = 1'b0;
    out_ready = 1'b1;
    drain("t4_drain");

    // Strobe coinciding with the eof transfer
    applyStimulus(24'h000001, 55, 1'b1);
    applyStimulus(24'h0000C0, 56, 1'b1);
    checkOutput("t5_valid", 32'(out_valid), 1);
    checkOutput("t5_sof",   32'(out_sof), 1);
    checkOutput("t5_chan",  32'(out_chan), 6);
    checkOutput("t5_ovr",   32'(ovr_cnt), 0);
    drain("t5_drain");

    // Reset in the middle of a frame
    applyStimulus(24'hFFFFFF, 66, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid && out_chan == 7) begin
        found = 1'b1;
        break;
      end
      wait_clk();
    end
    checkOutput("t6_reach7", 32'(found), 1);
    out_ready = 1'b0;
    reset = 1'b1;
    wait_clk();
    checkOutput("t6_valid", 32'(out_valid), 0);
    checkOutput("t6_data",  32'(out_data), 0);
    checkOutput("t6_chan",  32'(out_chan), 0);
    checkOutput("t6_eof",   32'(out_eof), 0);
    checkOutput("t6_busy",  32'(busy), 0);
    reset = 1'b0;
    q.delete();
    out_ready = 1'b1;
    applyStimulus(24'h000000, 77, 1'b0);
    checkOutput("t6_nomask_valid", 32'(out_valid), 0);
    checkOutput("t6_nomask_ovr",   32'(ovr_cnt), 0);
    checkOutput("t6_nomask_flag",  32'(ovr_flag), 0);
    repeat (3) wait_clk();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
